// File: rtl/pulse_tx_sched_pkg.sv
// Shared definitions for the pulse-transmitter frame scheduler.
//   - sched_state_e : scheduler FSM states
//   - descriptor field offsets/widths for one 23-bit frame descriptor slice
//   - ID_W          : width of a requester index (supports up to 8 requesters)
package pulse_tx_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StGap   = 2'd3
  } sched_state_e;

  // Descriptor layout: [6:0] end_index, [13:7] loopback_index,
  // [21:14] loop_count, [22] carrier_en.
  localparam int unsigned DESC_W       = 23;
  localparam int unsigned END_LSB      = 0;
  localparam int unsigned END_W        = 7;
  localparam int unsigned LOOPBACK_LSB = 7;
  localparam int unsigned LOOPBACK_W   = 7;
  localparam int unsigned COUNT_LSB    = 14;
  localparam int unsigned COUNT_W      = 8;
  localparam int unsigned CARRIER_BIT  = 22;

  localparam int unsigned ID_W = 3;

endpackage

// File: rtl/pulse_tx_rr_arbiter.sv
// Combinational round-robin pick.
// Searches req starting at ptr+1 (wrapping at NUM_REQ-1) and returns the first
// set bit. The pointer register is owned by the parent.
//   req        in   per-requester request levels
//   ptr        in   index of the last winner
//   winner_oh  out  one-hot winner (zero when no request)
//   winner_idx out  binary index of the winner
//   any_req    out  at least one request pending
module pulse_tx_rr_arbiter
  import pulse_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [ID_W-1:0]    winner_idx,
  output logic               any_req
);

  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] cand_oh;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_req    = 1'b0;
    cand       = ptr;
    cand_oh    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Step to the next candidate; '>=' also folds any out-of-range pointer.
      cand    = (cand >= ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      cand_oh = NUM_REQ'(1) << cand;
      if (!any_req && ((req & cand_oh) != '0)) begin
        winner_oh  = cand_oh;
        winner_idx = cand;
        any_req    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_tx_frame_scheduler.sv
// Pulse-transmitter frame scheduler.
// Shares one pulse-transmitter engine between NUM_REQ requesters with
// round-robin arbitration. Per frame it latches the winner's descriptor,
// raises the engine start level, follows the engine active level until the
// frame ends (or is aborted), then holds start low for a programmable guard gap
// before reporting completion and accepting the next request.
//
// Optional build macro PULSE_TX_SCHED_TIMEOUT_EN: adds a START watchdog of
// TIMEOUT_CYCLES cycles and the timeout_err output.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   req           per-requester request level, held until its gnt bit
//   desc_flat     per-requester 23-bit descriptors, requester i at [i*23 +: 23]
//   gap_cycles    guard gap after each frame (GAP lasts gap_cycles+1 cycles)
//   abort         terminate the frame in flight (ignored in IDLE/GAP)
//   eng_active    engine output-valid level
//   eng_start     engine start level (engine resets while low)
//   eng_cfg       latched descriptor of the frame in flight
//   gnt           one-hot 1-cycle grant pulse
//   done          one-hot 1-cycle completion pulse (first GAP cycle)
//   done_aborted  qualifies done: frame was aborted or timed out
//   busy          scheduler not idle
//   active_id     index of the current/last granted requester
//   timeout_err   (macro only) START watchdog expired, pulses with done
module pulse_tx_frame_scheduler
  import pulse_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DESC_W-1:0] desc_flat,
  input  logic [GAP_W-1:0]          gap_cycles,
  input  logic                      abort,
  input  logic                      eng_active,
  output logic                      eng_start,
  output logic [DESC_W-1:0]         eng_cfg,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      done_aborted,
  output logic                      busy,
  output logic [ID_W-1:0]           active_id
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  sched_state_e        state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                eng_start_q, eng_start_d;
  logic [DESC_W-1:0]   eng_cfg_q, eng_cfg_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                done_aborted_q, done_aborted_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                enter_gap;
  logic                gap_aborted;

  logic [NUM_REQ-1:0]  win_oh;
  logic [ID_W-1:0]     win_idx;
  logic                any_req;
  logic [DESC_W-1:0]   win_desc;

`ifdef PULSE_TX_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  pulse_tx_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .req        (req),
    .ptr        (ptr_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .any_req    (any_req)
  );

  // Descriptor of the current winner; constant loop index keeps the mux simple.
  always_comb begin
    win_desc = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_desc = desc_flat[i*DESC_W +: DESC_W];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    eng_start_d    = eng_start_q;
    eng_cfg_d      = eng_cfg_q;
    gnt_d          = '0;
    done_d         = '0;
    done_aborted_d = 1'b0;
    active_id_d    = active_id_q;
    gap_cnt_d      = gap_cnt_q;
    enter_gap      = 1'b0;
    gap_aborted    = 1'b0;
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
    wd_cnt_d       = wd_cnt_q;
    timeout_err_d  = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d     = StStart;
          eng_start_d = 1'b1;
          gnt_d       = win_oh;
          eng_cfg_d   = win_desc;
          active_id_d = win_idx;
          ptr_d       = win_idx;
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
          wd_cnt_d    = '0;
`endif
        end
      end

      StStart: begin
        if (abort) begin
          enter_gap   = 1'b1;
          gap_aborted = 1'b1;
        end else if (eng_active) begin
          state_d = StRun;
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
        end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Engine never came up: finish the frame as an abort.
          enter_gap     = 1'b1;
          gap_aborted   = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
      end

      StRun: begin
        // abort wins over a coincident eng_active fall.
        if (abort) begin
          enter_gap   = 1'b1;
          gap_aborted = 1'b1;
        end else if (!eng_active) begin
          enter_gap = 1'b1;
        end
      end

      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Common frame-end path: done is registered so it lands in the first GAP cycle.
    if (enter_gap) begin
      state_d        = StGap;
      eng_start_d    = 1'b0;
      gap_cnt_d      = gap_cycles;
      done_d         = NUM_REQ'(1) << active_id_q;
      done_aborted_d = gap_aborted;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ptr_q          <= ID_W'(NUM_REQ - 1);
      eng_start_q    <= 1'b0;
      eng_cfg_q      <= '0;
      gnt_q          <= '0;
      done_q         <= '0;
      done_aborted_q <= 1'b0;
      active_id_q    <= '0;
      gap_cnt_q      <= '0;
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
      wd_cnt_q       <= '0;
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      eng_start_q    <= eng_start_d;
      eng_cfg_q      <= eng_cfg_d;
      gnt_q          <= gnt_d;
      done_q         <= done_d;
      done_aborted_q <= done_aborted_d;
      active_id_q    <= active_id_d;
      gap_cnt_q      <= gap_cnt_d;
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
      wd_cnt_q       <= wd_cnt_d;
      timeout_err_q  <= timeout_err_d;
`endif
    end
  end

  assign eng_start    = eng_start_q;
  assign eng_cfg      = eng_cfg_q;
  assign gnt          = gnt_q;
  assign done         = done_q;
  assign done_aborted = done_aborted_q;
  assign busy         = (state_q != StIdle);
  assign active_id    = active_id_q;
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
  assign timeout_err  = timeout_err_q;
`endif

endmodule

// File: tb/tb_pulse_tx_frame_scheduler.sv
// Scoreboard bench for pulse_tx_frame_scheduler: a stimulus process predicts
// grants/completions from the pending-request set and round-robin rule and
// queues them; a negedge monitor pops and compares whenever gnt/done appear.
module tb_pulse_tx_frame_scheduler;
  import pulse_tx_sched_pkg::*;

  localparam int NR      = 4;
  localparam int GW      = 16;
  localparam int DW      = 23;
  localparam int NFRAMES = 40;
  localparam int ENG_LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] desc_flat = '0;
  logic [GW-1:0]    gap_cycles = '0;
  logic             abort = 1'b0;
  logic             eng_active = 1'b0;
  logic             eng_start;
  logic [DW-1:0]    eng_cfg;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic             done_aborted;
  logic             busy;
  logic [2:0]       active_id;
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
  logic             timeout_err;
`endif

  always #5 clk = ~clk;

  pulse_tx_frame_scheduler #(
    .NUM_REQ        (NR),
    .GAP_W          (GW),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .desc_flat    (desc_flat),
    .gap_cycles   (gap_cycles),
    .abort        (abort),
    .eng_active   (eng_active),
    .eng_start    (eng_start),
    .eng_cfg      (eng_cfg),
    .gnt          (gnt),
    .done         (done),
    .done_aborted (done_aborted),
    .busy         (busy),
    .active_id    (active_id)
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  typedef struct {
    int            id;
    logic [DW-1:0] cfg;
  } gnt_exp_t;

  typedef struct {
    int id;
    bit aborted;
  } done_exp_t;

  gnt_exp_t      gq[$];
  done_exp_t     dq[$];
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] desc_arr[NR];
  logic [NR-1:0] pending = '0;
  int            mptr = NR - 1;
  int            run_len = 20;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic drive_desc();
    for (int i = 0; i < NR; i++) desc_flat[i*DW +: DW] = desc_arr[i];
  endtask

  // Round-robin rule: first pending requester after the last winner, with wrap.
  task automatic predict_grant();
    gnt_exp_t e;
    for (int i = 1; i <= NR; i++) begin
      int c;
      c = (mptr + i) % NR;
      if (pending[c]) begin
        e.id  = c;
        e.cfg = desc_arr[c];
        gq.push_back(e);
        mptr = c;
        return;
      end
    end
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (gnt == '0 && n < 1000);
    if (gnt == '0) begin
      failures++;
      $display("FAIL gnt_timeout: no grant after %0d cycles, expected requester %0d", n, mptr);
      finish_run();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((dq.size() != 0 || gq.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (dq.size() != 0 || gq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d grants and %0d completions outstanding, expected 0",
               gq.size(), dq.size());
      finish_run();
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Engine model: active rises ENG_LAT cycles after the start rise, stays up
  // run_len cycles, and collapses whenever start is low.
  initial begin : engine
    logic prev;
    int   lat;
    int   left;
    prev = 1'b0;
    lat  = -1;
    left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (eng_start !== 1'b1) begin
        eng_active = 1'b0;
        lat        = -1;
      end else if (!prev) begin
        lat = 0;
      end else if (lat >= 0) begin
        lat++;
        if (lat == ENG_LAT) begin
          eng_active = 1'b1;
          left       = run_len;
          lat        = -1;
        end
      end else if (eng_active) begin
        left--;
        if (left <= 0) eng_active = 1'b0;
      end
      prev = (eng_start === 1'b1);
    end
  end

  initial begin : monitor
    int            busy_chk;
    int            low_cnt;
    int            exp_low;
    logic          prev_start;
    logic [DW-1:0] cur_cfg;
    logic [NR-1:0] oh;
    gnt_exp_t      ge;
    done_exp_t     de;
    busy_chk   = 0;
    low_cnt    = 0;
    exp_low    = 0;
    prev_start = 1'b0;
    cur_cfg    = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        busy_chk   = 0;
        low_cnt    = 0;
        exp_low    = 0;
        prev_start = 1'b0;
      end else begin
        if (gnt !== '0) begin
          if (gq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_gnt: got 0x%0h expected no grant at %0t", gnt, $time);
          end else begin
            ge = gq.pop_front();
            oh = NR'(1) << ge.id;
            chk("gnt", 64'(gnt), 64'(oh));
            chk("gnt_cfg", 64'(eng_cfg), 64'(ge.cfg));
            chk("gnt_active_id", 64'(active_id), 64'(ge.id));
            chk("gnt_busy", 64'(busy), 64'd1);
            cur_cfg = ge.cfg;
          end
        end
        if (done !== '0) begin
          if (dq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got 0x%0h expected no completion at %0t", done, $time);
          end else begin
            de = dq.pop_front();
            oh = NR'(1) << de.id;
            chk("done", 64'(done), 64'(oh));
            chk("done_aborted", 64'(done_aborted), 64'(de.aborted));
            chk("done_cfg_stable", 64'(eng_cfg), 64'(cur_cfg));
            chk("done_start_low", 64'(eng_start), 64'd0);
`ifdef PULSE_TX_SCHED_TIMEOUT_EN
            chk("done_timeout_err", 64'(timeout_err), 64'd0);
`endif
          end
          busy_chk = int'(gap_cycles) + 1;
          exp_low  = int'(gap_cycles) + 2;
        end else if (busy_chk > 0) begin
          busy_chk--;
          if (busy_chk == 0) chk("busy_clear_after_gap", 64'(busy), 64'd0);
        end
        if (eng_start === 1'b1 && !prev_start) begin
          if (exp_low > 0) begin
            chk("start_low_gap", 64'(low_cnt >= exp_low), 64'd1);
          end
          low_cnt = 0;
        end else if (eng_start !== 1'b1) begin
          low_cnt++;
        end
        prev_start = (eng_start === 1'b1);
      end
    end
  end

  initial begin : stim
    done_exp_t de;
    for (int i = 0; i < NR; i++) desc_arr[i] = DW'($urandom());
    desc_arr[0][6:0] = 7'd5;
    drive_desc();
    gap_cycles = GW'(3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_aborted", 64'(done_aborted), 64'd0);
    chk("rst_active_id", 64'(active_id), 64'd0);
    chk("rst_eng_cfg", 64'(eng_cfg), 64'd0);
    rst_n = 1'b1;

    // First frame: lone request from requester 0.
    pending = NR'(1);
    req     = pending;
    predict_grant();

    for (int f = 0; f < NFRAMES; f++) begin
      int w;
      int k;
      bit ab;
      if (pending == '0) begin
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1;
        pending = NR'($urandom_range(1, (1 << NR) - 1));
        req     = pending;
        predict_grant();
      end
      wait_gnt();
      w = mptr;
      if (f == 0) begin
        ab      = 1'b0;
        run_len = 20;
      end else begin
        ab      = ($urandom_range(0, 2) == 0);
        run_len = $urandom_range(1, 20);
      end
      // Abort lands from START (k<0) up to the very cycle active falls (k=run_len).
      k          = int'($urandom_range(0, run_len + 2)) - 2;
      gap_cycles = (f == 0) ? GW'(3) : GW'($urandom_range(0, 7));
      de.id      = w;
      de.aborted = ab;
      dq.push_back(de);

      for (int i = 0; i < NR; i++) desc_arr[i] = DW'($urandom());
      drive_desc();

      if (f == NFRAMES - 1) begin
        pending = '0;
      end else if (f < 5) begin
        pending = '1;
      end else begin
        pending = (pending & ~(NR'(1) << w) & NR'($urandom())) |
                  (NR'($urandom()) & NR'($urandom()));
      end
      req = pending;
      if (pending != '0) predict_grant();

      if (ab) begin
        repeat (ENG_LAT + k) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
      end
    end
    drain();

    // Reset in the middle of RUN: no completion, then requester 0 wins first.
    pending = NR'(2);
    req     = pending;
    predict_grant();
    wait_gnt();
    run_len    = 20;
    gap_cycles = GW'(3);
    pending    = '0;
    req        = '0;
    repeat (ENG_LAT + 5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_eng_start", 64'(eng_start), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_active_id", 64'(active_id), 64'd0);
    chk("midrst_eng_cfg", 64'(eng_cfg), 64'd0);
    rst_n = 1'b1;
    mptr    = NR - 1;
    pending = '1;
    req     = pending;
    predict_grant();
    wait_gnt();
    run_len    = 5;
    de.id      = mptr;
    de.aborted = 1'b0;
    dq.push_back(de);
    pending = '0;
    req     = '0;
    drain();

    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    finish_run();
  end

endmodule
